// File: rtl/add_sub_pipe.sv
// Pipelined two's-complement adder/subtractor.
// Adds one slice per stage and registers the carry between stages.
module add_sub_pipe #(
   parameter int WIDTH  = 32,
   parameter int STAGES = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] X,
   input  logic [WIDTH-1:0] Y,
   input  logic             sub,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out,
   output logic             carry,
   output logic             overflow,
   output logic             zero
);

   localparam int S = WIDTH / STAGES;
   localparam int L = STAGES - 1;

   for (genvar k = 0; k < STAGES; k++) begin : g_st
      logic             v;
      logic             c;
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      logic [WIDTH-1:0] r;
      logic             ld;
      logic             sv;
      logic             sc;
      logic [WIDTH-1:0] sa;
      logic [WIDTH-1:0] sb;
      logic [WIDTH-1:0] sr;
      logic [WIDTH-1:0] nr;
      logic [S:0]       sum;
      logic             unused_ab;

      // Operand words ride along whole; only their upper slices still matter.
      assign unused_ab = ^{a, b};

      if (k == 0) begin : g_in
         assign sv = in_valid;
         assign sa = X;
         assign sb = sub ? ~Y : Y;
         assign sr = '0;
         assign sc = sub | cin;
      end else begin : g_mid
         assign sv = g_st[k-1].v;
         assign sa = g_st[k-1].a;
         assign sb = g_st[k-1].b;
         assign sr = g_st[k-1].r;
         assign sc = g_st[k-1].c;
      end

      if (k == L) begin : g_last
         assign ld = !v || out_ready;
      end else begin : g_chain
         assign ld = !v || g_st[k+1].ld;
      end

      assign sum = {1'b0, sa[k*S +: S]}
                 + {1'b0, sb[k*S +: S]}
                 + {{S{1'b0}}, sc};

      always_comb begin
         nr = sr;
         nr[k*S +: S] = sum[S-1:0];
      end

      always_ff @(posedge clk) begin
         if (reset) begin
            v <= 1'b0;
            c <= 1'b0;
            a <= '0;
            b <= '0;
            r <= '0;
         end else if (ld) begin
            v <= sv;
            c <= sum[S];
            a <= sa;
            b <= sb;
            r <= nr;
         end
      end
   end

   assign in_ready  = g_st[0].ld;
   assign out_valid = g_st[L].v;
   assign out       = g_st[L].r;
   assign carry     = g_st[L].c;

   assign overflow = (g_st[L].a[WIDTH-1] == g_st[L].b[WIDTH-1])
                  && (g_st[L].r[WIDTH-1] != g_st[L].a[WIDTH-1]);

   // Gated so an empty (or freshly reset) final stage never reports zero.
   assign zero = g_st[L].v && ~|g_st[L].r;

endmodule

// File: doc/add_sub_pipe.md
# add_sub_pipe

Parametrised, pipelined two's-complement adder/subtractor for the MIPS datapath; it is the successor to the single-cycle 32-bit ripple adder. The operand width is split into STAGES equal slices. One slice is added per stage, and the inter-slice carry is registered between stages, so long carry chains do not limit the clock. A valid/ready handshake with full backpressure lets the ALU and multi-cycle units stream operations back-to-back. Carry, signed-overflow and zero flags are produced alongside the result.

## Interface
- WIDTH, 32, operand/result width; must be a multiple of STAGES.
- STAGES, 4, pipeline depth and slice count; slice width S = WIDTH/STAGES, must be ≥1.
- clk  in  1  rising-edge clock, the only clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  operation offered this cycle.
- in_ready  out  1  block accepts an operation this cycle.
- X  in  WIDTH  operand A.
- Y  in  WIDTH  operand B.
- sub  in  1  0 computes X+Y+cin; 1 computes X+~Y+1, where cin is ignored.
- cin  in  1  carry-in for add mode.
- out_valid  out  1  result present.
- out_ready  in  1  consumer takes the result this cycle.
- out  out  WIDTH  result.
- carry  out  1  carry out of bit WIDTH-1; in sub mode, 1 means no borrow.
- overflow  out  1  signed overflow.
- zero  out  1  out == 0.

## Operation
- Transfer at the input occurs when in_valid && in_ready. Transfer at the output occurs when out_valid && out_ready.
- Stage k (0..STAGES-1) holds the following registers:
  - v[k], the stage's valid bit.
  - The result slices computed so far.
  - The registered carry c[k].
  - The not-yet-used upper slices of X and the effective B (Y, or ~Y in sub mode).
  - Sign bits needed for the overflow computation.
- Stage 0 adds slice 0 with carry-in cin (add mode) or 1 (sub mode). Stage k adds slice k with c[k-1]. The carry of the final slice is `carry`.
- overflow = (A[W-1] == Beff[W-1]) && (out[W-1] != A[W-1]), where Beff is the effective B. zero is the NOR of all result bits, evaluated in the final stage.
- Advance rule: stage k loads from stage k-1 (or from the input, for k=0) when !v[k] || advance[k+1]. The last stage's advance term is out_ready.
  - A stage whose predecessor is empty clears v[k] when it advances.
  - A stage that does not advance holds all of its registers unchanged.
- in_ready = !v[0] || advance[1], i.e. a combinational ready chain from out_ready. No bubbles appear while out_ready=1.
- Ordering is strict FIFO. Each accepted operation produces exactly one result; none are dropped or duplicated.
- Arithmetic is modulo 2^WIDTH; all widths are unsigned slices except for the overflow rule above.

## Timing
- Reset clears every v[k]. During reset and in the first cycle after it: out_valid=0, out=0, carry=0, overflow=0, zero=0. in_ready is 1 in the first cycle after reset.
- Data registers other than the valid bits are also cleared to 0 on reset, so outputs are deterministic.
- Latency: an operation accepted at edge n produces out_valid=1 after edge n+STAGES-1, i.e. STAGES cycles of pipeline occupancy.
- Throughput: one operation per cycle while out_ready=1.
- While out_valid && !out_ready: out, carry, overflow and zero stay stable. The pipeline compacts, so up to STAGES operations are held, after which in_ready=0.
- Simultaneous accept and emit with a full pipeline is legal: in_ready=1 in that cycle because out_ready=1.
- In-flight operations and results are discarded at a reset asserted mid-stream. Any handshake in a reset cycle is ignored.
- STAGES=1 degenerates to a single registered adder with latency 1 and in_ready = !out_valid || out_ready.

## Test plan
- Carry through all slices (WIDTH=32, STAGES=4): add, 0xFFFFFFFF + 0x00000001, cin=0 → out=0x00000000, carry=1, zero=1, overflow=0. out_valid rises 4 cycles after acceptance.
- Signed overflow: add, 0x7FFFFFFF + 0x00000001 → out=0x80000000, overflow=1, carry=0. Sub, 0x80000000 − 0x00000001 → out=0x7FFFFFFF, overflow=1, carry=1.
- Subtraction with borrow: sub, 5 − 7 → out=0xFFFFFFFE, carry=0, overflow=0, zero=0. Sub, 7 − 7 → out=0, carry=1, zero=1.
- cin across a slice boundary: add, 0x0000FFFF + 0x00000000, cin=1 → out=0x00010000, carry=0.
- Backpressure stream: feed 20 random operations with in_valid held high while out_ready follows a pseudo-random pattern (including a 6-cycle low run).
  - Results must match a reference model, in order, with no loss or duplication.
  - in_ready must fall after 4 operations are held.
  - Outputs must be stable while stalled.
- Reset mid-stream: assert reset for 1 cycle with 3 operations in flight → no result from them ever appears. out_valid=0 and in_ready=1 the next cycle. The next operation completes after 4 cycles with the correct value.
